rf_write_scheduler: RTL and testbench

- Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters: req0 = ALU writeback, req1 = load/store unit writeback.
- Each requester has its own small FIFO. A round-robin arbiter drains the FIFOs, issuing one registered write per cycle.
- Publishes a pending-write mask. The hazard/stall logic uses it to hold readers of registers whose writes are still queued.

---
 rtl/rf_sched_pkg.sv | 17 +
 rtl/rf_write_scheduler_wb_fifo.sv | 65 ++++++
 rtl/rf_write_scheduler.sv | 110 +++++++++++
 tb/tb_rf_write_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds the requester indices, the default widths and the queued write entry type.
package rf_sched_pkg;

    localparam int   NUM_REQ = 2;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/rf_write_scheduler_wb_fifo.sv
// Small synchronous writeback FIFO with per-slot valid bits and raw storage
// exposed so the owner can build a pending-register mask from every queued entry.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH-1:0][W-1:0]   entries
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign entries  = mem;

    // Storage needs no reset; the valid bits alone say which slots mean anything.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + PW'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + PW'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the single register-file write port between the ALU and LSU writeback
// paths through two FIFOs and a round-robin arbiter, and publishes a pending-write mask.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AW-1:0]        req0_addr,
    input  logic [DW-1:0]        req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AW-1:0]        req1_addr,
    input  logic [DW-1:0]        req1_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic [(2**AW)-1:0]   pend_mask,
    output logic                 idle
);

    localparam int W  = AW + DW;
    localparam int CW = $clog2(DEPTH + 1);

    logic                    full0, full1, empty0, empty1;
    logic [CW-1:0]           count0, count1;
    logic [W-1:0]            head0, head1;
    logic [DEPTH-1:0]        vld0, vld1;
    logic [DEPTH-1:0][W-1:0] ent0, ent1;
    logic                    push0, push1;
    logic                    gnt0, gnt1;
    logic                    last_grant;

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;

    // Writes to x0 finish the handshake but are dropped before the FIFO.
    assign push0 = req0_valid & req0_ready & (req0_addr != '0);
    assign push1 = req1_valid & req1_ready & (req1_addr != '0);

    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push        (push0),
        .push_data   ({req0_addr, req0_data}),
        .pop         (gnt0),
        .pop_data    (head0),
        .full        (full0),
        .empty       (empty0),
        .count       (count0),
        .entry_valid (vld0),
        .entries     (ent0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push        (push1),
        .push_data   ({req1_addr, req1_data}),
        .pop         (gnt1),
        .pop_data    (head1),
        .full        (full1),
        .empty       (empty1),
        .count       (count1),
        .entry_valid (vld1),
        .entries     (ent1)
    );

    // Under contention the requester that did not win last time goes next.
    assign gnt0 = ~empty0 & (empty1 | (last_grant == REQ_LSU));
    assign gnt1 = ~empty1 & (empty0 | (last_grant == REQ_ALU));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            last_grant <= REQ_LSU;
        end else begin
            rf_we <= gnt0 | gnt1;
            if (gnt0) begin
                rf_wa      <= head0[W-1 -: AW];
                rf_wd      <= head0[DW-1:0];
                last_grant <= REQ_ALU;
            end else if (gnt1) begin
                rf_wa      <= head1[W-1 -: AW];
                rf_wd      <= head1[DW-1:0];
                last_grant <= REQ_LSU;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld0[i]) pend_mask[ent0[i][W-1 -: AW]] = 1'b1;
            if (vld1[i]) pend_mask[ent1[i][W-1 -: AW]] = 1'b1;
        end
        if (rf_we) pend_mask[rf_wa] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign idle = (count0 == '0) & (count1 == '0) & ~rf_we;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: a fixed vector table, directed
// corner-case sequences and random traffic compared against a queue-based model.
module tb_rf_write_scheduler;
    import rf_sched_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [31:0]   pend_mask;
    logic          idle;

    int checks = 0;
    int errors = 0;

    rf_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .pend_mask  (pend_mask),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per requester plus the visible output register.
    wr_entry_t q0[$];
    wr_entry_t q1[$];
    int        m_last;
    logic      m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    wr_entry_t wr_log[$];

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [31:0]   e_mask;
        logic          e_idle;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic [31:0] mask, logic idl);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_mask = mask; v.e_idle = idl;
        return v;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q0[i]) m[q0[i].addr] = 1'b1;
        foreach (q1[i]) m[q1[i].addr] = 1'b1;
        if (m_we) m[m_wa] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_last = 1;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
    endtask

    task automatic model_edge();
        bit r0, r1;
        int g;
        wr_entry_t e;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        g  = -1;
        if (q0.size() > 0 && q1.size() > 0) g = (m_last == 0) ? 1 : 0;
        else if (q0.size() > 0)              g = 0;
        else if (q1.size() > 0)              g = 1;
        m_we = (g >= 0);
        if (g == 0) begin
            e = q0.pop_front();
            m_wa = e.addr; m_wd = e.data; m_last = 0;
        end else if (g == 1) begin
            e = q1.pop_front();
            m_wa = e.addr; m_wd = e.data; m_last = 1;
        end
        if (req0_valid && r0 && req0_addr != 0) q0.push_back('{req0_addr, req0_data});
        if (req1_valid && r1 && req1_addr != 0) q1.push_back('{req1_addr, req1_data});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output();
        check("req0_ready", 64'(req0_ready), 64'(q0.size() < DEPTH));
        check("req1_ready", 64'(req1_ready), 64'(q1.size() < DEPTH));
        check("rf_we",      64'(rf_we),      64'(m_we));
        check("rf_wa",      64'(rf_wa),      64'(m_wa));
        check("rf_wd",      64'(rf_wd),      64'(m_wd));
        check("pend_mask",  64'(pend_mask),  64'(model_mask()));
        check("idle",       64'(idle),       64'(q0.size() == 0 && q1.size() == 0 && !m_we));
    endtask

    // Called at a falling edge: drive inputs, clock once, compare at the next falling edge.
    task automatic apply_stimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_output();
        if (rf_we) wr_log.push_back('{rf_wa, rf_wd});
    endtask

    task automatic idle_step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        #1;
        check_output();
        wr_log.delete();
    endtask

    initial begin
        tbl[0] = mk(1, 5, 32'h5,        0, 0, 0,      0, 0, 32'h0,  32'h20, 0);
        tbl[1] = mk(0, 0, 0,            0, 0, 0,      1, 5, 32'h5,  32'h20, 0);
        tbl[2] = mk(0, 0, 0,            0, 0, 0,      0, 5, 32'h5,  32'h0,  1);
        tbl[3] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,      0, 5, 32'h5,  32'h0,  1);
        tbl[4] = mk(0, 0, 0,            0, 0, 0,      0, 5, 32'h5,  32'h0,  1);
        tbl[5] = mk(1, 3, 32'h33,       1, 4, 32'h44, 0, 5, 32'h5,  32'h18, 0);
        tbl[6] = mk(0, 0, 0,            0, 0, 0,      1, 4, 32'h44, 32'h18, 0);
        tbl[7] = mk(0, 0, 0,            0, 0, 0,      1, 3, 32'h33, 32'h08, 0);
        tbl[8] = mk(0, 0, 0,            0, 0, 0,      0, 3, 32'h33, 32'h0,  1);

        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_idle", 64'(idle), 64'(1));
        check("reset_mask", 64'(pend_mask), 64'(0));

        // Single write, x0 discard and a two-requester pair from the table.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].v0 && tbl[i].a0 == 0) check("x0_ready", 64'(req0_ready), 64'(1));
            apply_stimulus(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            check($sformatf("tbl%0d_we", i),   64'(rf_we),     64'(tbl[i].e_we));
            check($sformatf("tbl%0d_wa", i),   64'(rf_wa),     64'(tbl[i].e_wa));
            check($sformatf("tbl%0d_wd", i),   64'(rf_wd),     64'(tbl[i].e_wd));
            check($sformatf("tbl%0d_mask", i), 64'(pend_mask), 64'(tbl[i].e_mask));
            check($sformatf("tbl%0d_idle", i), 64'(idle),      64'(tbl[i].e_idle));
        end

        // Sustained contention: strict alternation, req0 first after reset.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            apply_stimulus(1'b1, 5'd6, DW'(k), 1'b1, 5'd7, DW'(32'h100 + k));
            if (k == 1) check("cont_we_first", 64'(rf_we), 64'(0));
            else begin
                check($sformatf("cont_we_%0d", k), 64'(rf_we), 64'(1));
                check($sformatf("cont_wa_%0d", k), 64'(rf_wa), 64'((k % 2 == 0) ? 6 : 7));
            end
        end

        // Backpressure on req1 with order A, B, C preserved.
        do_reset();
        apply_stimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'hA);
        apply_stimulus(1'b1, 5'd1, 32'h2, 1'b1, 5'd2, 32'hB);
        check("bp_ready1_full", 64'(req1_ready), 64'(0));
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hC);
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hC);
        for (int k = 0; k < 5; k++) idle_step();
        begin
            logic [DW-1:0] seq[$];
            foreach (wr_log[i]) if (wr_log[i].addr == 2) seq.push_back(wr_log[i].data);
            check("bp_count", 64'(seq.size()), 64'(3));
            if (seq.size() == 3) begin
                check("bp_order0", 64'(seq[0]), 64'(32'hA));
                check("bp_order1", 64'(seq[1]), 64'(32'hB));
                check("bp_order2", 64'(seq[2]), 64'(32'hC));
            end
        end

        // Back-to-back writes on req0: count stays at 1, pointers wrap, order kept.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            apply_stimulus(1'b1, AW'(k), DW'(32'h200 + k), 1'b0, '0, '0);
            check($sformatf("wrap_ready_%0d", k), 64'(req0_ready), 64'(1));
        end
        idle_step();
        idle_step();
        check("wrap_count", 64'(wr_log.size()), 64'(10));
        foreach (wr_log[i]) begin
            check($sformatf("wrap_addr_%0d", i), 64'(wr_log[i].addr), 64'(i + 1));
            check($sformatf("wrap_data_%0d", i), 64'(wr_log[i].data), 64'(32'h200 + i + 1));
        end
        check("wrap_idle", 64'(idle), 64'(1));

        // Asynchronous reset between edges while writes are queued and in flight.
        do_reset();
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 5'd8, DW'(k), 1'b1, 5'd9, DW'(k));
        check("ar_we_before", 64'(rf_we), 64'(1));
        #2 rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        model_reset();
        check("ar_we_drop",  64'(rf_we),      64'(0));
        check("ar_mask",     64'(pend_mask),  64'(0));
        check("ar_idle",     64'(idle),       64'(1));
        check("ar_ready0",   64'(req0_ready), 64'(1));
        check("ar_ready1",   64'(req1_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        wr_log.delete();
        for (int k = 0; k < 4; k++) idle_step();
        check("ar_no_stale", 64'(wr_log.size()), 64'(0));
        apply_stimulus(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
        idle_step();
        check("ar_first_we", 64'(rf_we), 64'(1));
        check("ar_first_wa", 64'(rf_wa), 64'(10));
        idle_step();
        idle_step();

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            apply_stimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                           1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
        end
        for (int k = 0; k < 6; k++) idle_step();
        check("rand_idle", 64'(idle), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
